// File: rtl/req_enc_pkg.sv
// Shared types and defaults for the request encoder: FSM state, sizing defaults
// and the one-hot helper used to turn an index back into a clear mask.
package req_enc_pkg;

   typedef enum logic {IDLE, PRESENT} state_t;

   localparam int N_DEF     = 4;
   localparam int IDX_W_DEF = 2;
   localparam int CNT_W_DEF = 8;

   // Wide result so callers of any size up to 32 lines can truncate to their own N.
   function automatic logic [31:0] onehot(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/req_encoder_4x2_prio_sel.sv
// Combinational lowest-index-first finder: returns the index of the lowest set
// bit of vec and flags whether any bit is set.
module prio_sel
   import req_enc_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_encoder_4x2.sv
// Captures request lines into a pending register, presents the highest-priority
// pending index on a valid/ack handshake and counts requests lost to a busy bit.
module req_encoder_4x2
   import req_enc_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [N-1:0]     pending,
   output logic [CNT_W-1:0] drop_cnt
);

   state_t           state, state_next;
   logic [IDX_W-1:0] idx_next;
   logic [N-1:0]     cur_mask, clr_mask, rem, pending_next, drop_bits;
   logic [IDX_W-1:0] pend_idx, rem_idx;
   logic             pend_any, rem_any, accept;
   logic [CNT_W:0]   drop_num, drop_sum;
   logic [CNT_W-1:0] drop_next;

   assign out_valid = (state == PRESENT);
   assign accept    = out_valid && out_ack;
   assign cur_mask  = N'(onehot(5'(out_idx)));
   assign clr_mask  = accept ? cur_mask : '0;
   assign rem       = pending & ~cur_mask;

   prio_sel #(.N(N), .IDX_W(IDX_W)) u_prio_pend (
      .vec (pending),
      .idx (pend_idx),
      .any (pend_any)
   );

   prio_sel #(.N(N), .IDX_W(IDX_W)) u_prio_rem (
      .vec (rem),
      .idx (rem_idx),
      .any (rem_any)
   );

   // A request on a bit being acked this cycle re-arms it rather than counting as a drop.
   always_comb begin
      pending_next = pending & ~clr_mask;
      drop_bits    = '0;
      drop_num     = '0;
      if (en) begin
         pending_next = pending_next | req;
         drop_bits    = req & pending & ~clr_mask;
      end
      for (int i = 0; i < N; i++) begin
         drop_num = drop_num + (CNT_W + 1)'(drop_bits[i]);
      end
      drop_sum  = {1'b0, drop_cnt} + drop_num;
      drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   always_comb begin
      state_next = state;
      idx_next   = out_idx;
      case (state)
         IDLE: begin
            if (en && pend_any) begin
               state_next = PRESENT;
               idx_next   = pend_idx;
            end
         end
         PRESENT: begin
            if (out_ack) begin
               if (rem_any && en) begin
                  idx_next = rem_idx;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         out_idx  <= '0;
         pending  <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_next;
         out_idx  <= idx_next;
         pending  <= pending_next;
         drop_cnt <= drop_next;
      end
   end

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Directed self-checking bench for req_encoder_4x2 with hand-computed expectations.
module tb_req_encoder_4x2;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       out_ack;
   logic [1:0] out_idx;
   logic       out_valid;
   logic [3:0] pending;
   logic [7:0] drop_cnt;

   int checks;
   int failures;

   req_encoder_4x2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .pending   (pending),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      en       = 1'b1;
      req      = 4'b0000;
      out_ack  = 1'b0;
      rst_n    = 1'b1;
      #2;
      do_reset();
      check_output("rst_valid", int'(out_valid), 0);
      check_output("rst_pending", int'(pending), 0);

      // Reset mid-presentation with a nonzero drop count
      tick();
      req = 4'b0110;
      tick();
      tick();
      req = 4'b0000;
      check_output("mid_valid", int'(out_valid), 1);
      check_output("mid_idx", int'(out_idx), 1);
      check_output("mid_drop", int'(drop_cnt), 2);
      rst_n = 1'b0;
      #1;
      check_output("async_valid", int'(out_valid), 0);
      check_output("async_idx", int'(out_idx), 0);
      check_output("async_pending", int'(pending), 0);
      check_output("async_drop", int'(drop_cnt), 0);
      #1;
      rst_n = 1'b1;

      // Single request: two edges of latency, then ack clears it
      tick();
      req = 4'b0100;
      tick();
      req = 4'b0000;
      check_output("single_pend", int'(pending), 4);
      check_output("single_valid_early", int'(out_valid), 0);
      tick();
      check_output("single_valid", int'(out_valid), 1);
      check_output("single_idx", int'(out_idx), 2);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check_output("single_ack_valid", int'(out_valid), 0);
      check_output("single_ack_pend", int'(pending), 0);

      // Priority and back-to-back presentation
      req = 4'b1011;
      tick();
      req = 4'b0000;
      tick();
      check_output("b2b_idx0", int'(out_idx), 0);
      check_output("b2b_valid0", int'(out_valid), 1);
      out_ack = 1'b1;
      tick();
      check_output("b2b_idx1", int'(out_idx), 1);
      check_output("b2b_valid1", int'(out_valid), 1);
      tick();
      check_output("b2b_idx3", int'(out_idx), 3);
      check_output("b2b_pend3", int'(pending), 8);
      tick();
      out_ack = 1'b0;
      check_output("b2b_done_valid", int'(out_valid), 0);
      check_output("b2b_done_pend", int'(pending), 0);

      // Drop on a busy bit, then same-cycle ack and re-arm
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      check_output("drop_pre_valid", int'(out_valid), 1);
      check_output("drop_pre_cnt", int'(drop_cnt), 0);
      req = 4'b0001;
      tick();
      check_output("drop_cnt1", int'(drop_cnt), 1);
      out_ack = 1'b1;
      tick();
      req     = 4'b0000;
      out_ack = 1'b0;
      check_output("rearm_pend", int'(pending), 1);
      check_output("rearm_drop", int'(drop_cnt), 1);
      check_output("rearm_gap_valid", int'(out_valid), 0);
      tick();
      check_output("rearm_valid", int'(out_valid), 1);
      check_output("rearm_idx", int'(out_idx), 0);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check_output("rearm_clear_pend", int'(pending), 0);

      // Enable gating
      en  = 1'b0;
      req = 4'b1111;
      tick();
      check_output("gate_pend", int'(pending), 0);
      tick();
      check_output("gate_valid", int'(out_valid), 0);
      en  = 1'b1;
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      check_output("gate_valid_on", int'(out_valid), 1);
      check_output("gate_idx", int'(out_idx), 3);

      // en=0 during presentation: held until ack, then idle with no new pick
      req = 4'b0010;
      tick();
      req = 4'b0000;
      en  = 1'b0;
      tick();
      check_output("hold_idx", int'(out_idx), 3);
      check_output("hold_valid", int'(out_valid), 1);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check_output("hold_ack_valid", int'(out_valid), 0);
      check_output("hold_ack_pend", int'(pending), 2);
      tick();
      check_output("hold_idle_valid", int'(out_valid), 0);
      en = 1'b1;

      // Drop counter saturation
      do_reset();
      req = 4'b1111;
      tick();
      check_output("sat_fill_drop", int'(drop_cnt), 0);
      for (int i = 0; i < 63; i++) tick();
      check_output("sat_252", int'(drop_cnt), 252);
      tick();
      check_output("sat_255", int'(drop_cnt), 255);
      for (int i = 0; i < 6; i++) tick();
      check_output("sat_hold", int'(drop_cnt), 255);
      check_output("sat_idx", int'(out_idx), 0);
      req = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/req_encoder_4x2.md
Name: req_encoder_4x2

Overview:
- Sequential counterpart of the team's 2-to-4 decoder.
- Captures one-hot/multi-hot request lines into a pending register and encodes the highest-priority pending request into a binary index.
- Presents that index on a valid/ack handshake and clears the bit on acknowledge.
- Sits between event sources and a consumer that drives the 2x4 decoder back to a one-hot select.

Parameters:
- N, 4, number of request lines.
- IDX_W, 2, index width; must equal $clog2(N).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enable; gates request capture and new selection.
- req  input  N  request pulses/levels, sampled every cycle.
- out_idx  output  IDX_W  encoded index of the presented request.
- out_valid  output  1  out_idx is valid.
- out_ack  input  1  consumer accepts out_idx; meaningful only while out_valid=1.
- pending  output  N  current pending register (status).
- drop_cnt  output  CNT_W  saturating count of requests lost because their bit was already pending.

Behaviour:
- Reset (rst_n=0, async): pending=0, out_valid=0, out_idx=0, drop_cnt=0, state=IDLE. Takes effect immediately, even mid-presentation; any unacked index is discarded.
- Priority: lowest index wins (bit 0 highest).
- Capture:
  - When en=1: pending_next = (pending & ~clr_mask) | req.
  - clr_mask = onehot(out_idx) when out_valid & out_ack, else 0.
  - When en=0: req is ignored and pending only loses clr_mask.
- Simultaneous ack and req on the same bit: the bit remains set (new event), no drop is counted.
- Drop counting:
  - Each cycle with en=1, count req bits that are already set in pending and not being cleared this cycle.
  - Add that count (0..N) to drop_cnt, saturating at 2^CNT_W-1.
- State machine, two states:
  - IDLE: out_valid=0. If en=1 and pending!=0, then at the next edge latch out_idx = priority(pending), set out_valid=1, go to PRESENT.
  - PRESENT: out_valid=1, out_idx held stable until ack.
    - On out_ack=1, let rem = pending & ~onehot(out_idx). Requests arriving this cycle are excluded from rem.
    - If rem!=0 and en=1: stay in PRESENT and load out_idx = priority(rem). This gives back-to-back presentation, one index per cycle.
    - Otherwise: out_valid=0, go to IDLE.
- en=0 while in PRESENT: the current presentation is held until ack, then the FSM returns to IDLE and no new selection is made.
- Latency: req asserted in cycle t -> pending set at edge t+1 -> out_valid at edge t+2 (from IDLE).
- out_ack while out_valid=0 is ignored.
- Width rules: drop_cnt uses saturating addition in CNT_W+1 bits, then clamps. out_idx is zero-extended from the priority finder.

Decomposition:
- Shared package req_enc_pkg:
  - state enum {IDLE, PRESENT}.
  - Parameters N/IDX_W/CNT_W defaults.
  - onehot(idx) function.
- One sub-module: prio_sel, a combinational lowest-index-first finder (vec[N] -> idx[IDX_W], any). Instantiated twice, once for pending and once for rem.

Test Plan:
- Reset mid-op: pending=4'b0110, out_valid=1, assert rst_n=0 -> out_valid=0, out_idx=0, pending=0, drop_cnt=0 immediately, without waiting for a clock edge.
- Single request: en=1, req=4'b0100 one cycle -> out_valid=1 with out_idx=2 two edges later. Ack -> out_valid=0, pending=0.
- Priority and back-to-back: req=4'b1011 one cycle, ack held high -> out_idx sequence 0,1,3 on consecutive cycles, then out_valid=0, pending=0.
- Drop and same-cycle re-arm:
  - pending=4'b0001 presented, req=4'b0001 without ack -> drop_cnt=1.
  - Then req=4'b0001 with ack -> pending bit0 stays 1, drop_cnt stays 1, out_idx=0 re-presented next cycle.
- Enable gating: en=0, req=4'b1111 -> pending unchanged (0), out_valid stays 0. Then en=1, req=4'b1000 -> out_idx=3.
- Saturation: CNT_W=8, pending=4'b1111, hold req=4'b1111 with en=1, no ack, for 70 cycles -> drop_cnt=255, not wrapping.
